fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Front-end fetch PC sequencer. It owns the fetch PC register that drives `fetch_pc` into IF1 and the IF1→fetch-buffer stage. It advances that PC sequentially when IF1 accepts, and arbitrates redirects from three sources: backend flush, privileged-instruction replay (`set_pc_from_PRIV` / `pc_from_PRIV`), and branch prediction. Each redirect bumps an epoch tag so downstream stages can drop stale fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h1C00_0000: fetch PC after reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  backend flush request; highest priority.
- `flush_target`  in  32  PC to fetch after flush.
- `priv_hold`  in  1  IF1 privileged-op FSM not idle (`set_pc_from_PRIV`).
- `priv_target`  in  32  resume PC from that FSM (`pc_from_PRIV`).
- `bp_redirect`  in  1  predictor taken redirect.
- `bp_target`  in  32  predicted target.
- `if1_allowin`  in  1  IF1 accepts the presented PC this cycle.
- `fetch_pc`  out  32  PC presented to IF1/icache.
- `fetch_pc_next`  out  32  sequential successor of `fetch_pc`, combinational.
- `fetch_valid`  out  1  `fetch_pc` is a real request, combinational from state.
- `fetch_epoch`  out  2  redirect epoch tag.
- `flush_cnt`  out  16  saturating count of accepted flushes.

## Operation
- Target alignment: every loaded target has bits [1:0] forced to 0.
- Sequential successor: `fetch_pc_next = {fetch_pc[31:3] + 29'd1, 3'b000}`. It is 8-byte-group aligned, so an odd-word PC (bit2 = 1) also advances to the next group. It wraps 32'hFFFF_FFF8 → 32'h0000_0000.
- FSM states: RUN, FLUSH_BUB, PRIV_WAIT. `fetch_valid` = (state == RUN) && !`priv_hold`.
- Any state, `flush` = 1:
  - `fetch_pc` ← `flush_target`, `fetch_epoch` += 1 (mod 4), `flush_cnt` += 1 (saturates at 16'hFFFF).
  - Next state FLUSH_BUB.
  - `flush` overrides `priv_hold`, `bp_redirect` and the sequential advance in the same cycle.
- RUN, no flush, checked in priority order:
  1. `priv_hold` = 1 → PRIV_WAIT, `fetch_pc` ← `priv_target`.
  2. Else `bp_redirect` = 1 → `fetch_pc` ← `bp_target`, epoch += 1, stay in RUN. The redirect is taken regardless of `if1_allowin`, because the held PC was never issued.
  3. Else `if1_allowin` = 1 → `fetch_pc` ← `fetch_pc_next`.
  4. Else hold.
- FLUSH_BUB (exactly 1 cycle, no flush):
  - `priv_hold` = 1 → PRIV_WAIT, else → RUN.
  - `fetch_pc` holds; `bp_redirect` is ignored.
- PRIV_WAIT, no flush:
  - `fetch_pc` ← `priv_target` every cycle; `bp_redirect` and `if1_allowin` are ignored.
  - When `priv_hold` = 0: → RUN, epoch += 1, `fetch_pc` ← `priv_target` (the last sampled value).
- Reset values: `fetch_pc` = RESET_PC, state = RUN, `fetch_epoch` = 0, `flush_cnt` = 0. So `fetch_valid` = 1 (unless `priv_hold`) and `fetch_pc_next` = RESET_PC + 8. Reset dominates `flush`.

## Timing
- Every redirect lands in `fetch_pc` at the first edge after it is sampled (1-cycle latency).
- Flush sampled at edge N:
  - `fetch_pc` = target and `fetch_valid` = 0 from N through N+1.
  - `fetch_valid` = 1 from N+1 onward, at the earliest, after the edge ending FLUSH_BUB.
- A PC counts as issued only at an edge with `fetch_valid` && `if1_allowin`; exactly one advance per such edge.
- `priv_hold` rising in RUN drops `fetch_valid` in the same cycle (combinational) and enters PRIV_WAIT at the next edge.
- The epoch increments once per redirect event, never twice in one cycle; 3 → 0 wraps silently.
- Reset mid-PRIV_WAIT or mid-FLUSH_BUB returns to RUN at RESET_PC with epoch 0 at the next edge.

## Test plan
- Reset, then `if1_allowin` = 1 for 3 cycles → `fetch_pc` sequence 1C00_0000, 1C00_0008, 1C00_0010, 1C00_0018. With `if1_allowin` = 0 the PC holds.
- Flush to 32'h1C00_1006 while `priv_hold` = 1 and `bp_redirect` = 1:
  - Next cycle `fetch_pc` = 1C00_1004, `fetch_valid` = 0, epoch = 1, `flush_cnt` = 1.
  - One cycle later `fetch_valid` = 1 if `priv_hold` has dropped.
- `priv_hold` high for 4 cycles with `priv_target` = 1C00_0204:
  - `fetch_valid` = 0 throughout.
  - After release `fetch_pc` = 1C00_0204, epoch increments by exactly 1, then advances to 1C00_0208.
- `bp_redirect` to 1C00_0500 while `if1_allowin` = 0 → `fetch_pc` = 1C00_0500 next cycle and epoch += 1. The following advance goes to 1C00_0508.
- `fetch_pc` = FFFF_FFFC, advance → 0000_0000. Five back-to-back redirects → epoch sequence 1, 2, 3, 0, 1.
- Force `flush_cnt` to FFFE, flush 3 times → FFFF, FFFF, FFFF.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch PC sequencer bundle: redirect sources in, fetch PC / epoch / flush count out.
// No storage; master drives redirects and if1_allowin, slave owns the fetch PC.
// Backpressure is carried by if1_allowin only.
interface fetch_pc_ctrl_if;
    logic        flush;
    logic [31:0] flush_target;
    logic        priv_hold;
    logic [31:0] priv_target;
    logic        bp_redirect;
    logic [31:0] bp_target;
    logic        if1_allowin;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic        fetch_valid;
    logic [1:0]  fetch_epoch;
    logic [15:0] flush_cnt;

    modport master (
        output flush, flush_target, priv_hold, priv_target,
               bp_redirect, bp_target, if1_allowin,
        input  fetch_pc, fetch_pc_next, fetch_valid, fetch_epoch, flush_cnt
    );

    modport slave (
        input  flush, flush_target, priv_hold, priv_target,
               bp_redirect, bp_target, if1_allowin,
        output fetch_pc, fetch_pc_next, fetch_valid, fetch_epoch, flush_cnt
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC sequencer: sequential advance plus flush > priv > predictor redirects.
// Latency: redirects land in fetch_pc one edge after sampling; fetch_pc_next is comb.
// Backpressure: PC advances only on fetch_valid && if1_allowin; redirects ignore it.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
    input  logic              clk,
    input  logic              rst,
    fetch_pc_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_FLUSH_BUB = 2'd1,
        ST_PRIV_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  epoch_q, epoch_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_seq;

    function automatic logic [31:0] align_word(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            epoch_q     <= 2'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            epoch_q     <= epoch_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        epoch_d     = epoch_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            state_d     = ST_FLUSH_BUB;
            pc_d        = align_word(bus.flush_target);
            epoch_d     = epoch_q + 2'd1;
            flush_cnt_d = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.priv_hold) begin
                        state_d = ST_PRIV_WAIT;
                        pc_d    = align_word(bus.priv_target);
                    end else if (bus.bp_redirect) begin
                        // Held PC was never issued, so the redirect needs no allowin.
                        pc_d    = align_word(bus.bp_target);
                        epoch_d = epoch_q + 2'd1;
                    end else if (bus.if1_allowin) begin
                        pc_d    = pc_seq;
                    end
                end
                ST_FLUSH_BUB: begin
                    state_d = bus.priv_hold ? ST_PRIV_WAIT : ST_RUN;
                end
                ST_PRIV_WAIT: begin
                    pc_d = align_word(bus.priv_target);
                    if (!bus.priv_hold) begin
                        state_d = ST_RUN;
                        epoch_d = epoch_q + 2'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        // Successor is 8-byte-group aligned, so an odd-word PC skips to the next group.
        pc_seq            = {pc_q[31:3] + 29'd1, 3'b000};
        bus.fetch_pc      = pc_q;
        bus.fetch_pc_next = pc_seq;
        bus.fetch_valid   = (state_q == ST_RUN) && !bus.priv_hold;
        bus.fetch_epoch   = epoch_q;
        bus.flush_cnt     = flush_cnt_q;
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_pc_ctrl;

    logic clk;
    logic rst;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl #(.RESET_PC(32'h1C00_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic [1:0]  ep;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] nxt;
            e   = exp_q.pop_front();
            nxt = {e.pc[31:3] + 29'd1, 3'b000};
            check("fetch_pc",      bus.fetch_pc,             e.pc);
            check("fetch_pc_next", bus.fetch_pc_next,        nxt);
            check("fetch_valid",   {31'd0, bus.fetch_valid}, {31'd0, e.vld});
            check("fetch_epoch",   {30'd0, bus.fetch_epoch}, {30'd0, e.ep});
            check("flush_cnt",     {16'd0, bus.flush_cnt},   {16'd0, e.cnt});
        end
    end

    // Drive one cycle of inputs; if chk, the state after the edge is expected to match.
    task automatic step(input logic r, input logic fl, input logic [31:0] ft,
                        input logic ph, input logic [31:0] pt,
                        input logic br, input logic [31:0] bt, input logic al,
                        input logic chk, input logic [31:0] e_pc, input logic e_vld,
                        input logic [1:0] e_ep, input logic [15:0] e_cnt);
        exp_t e;
        rst              = r;
        bus.flush        = fl;
        bus.flush_target = ft;
        bus.priv_hold    = ph;
        bus.priv_target  = pt;
        bus.bp_redirect  = br;
        bus.bp_target    = bt;
        bus.if1_allowin  = al;
        @(posedge clk);
        if (chk) begin
            e.pc  = e_pc;
            e.vld = e_vld;
            e.ep  = e_ep;
            e.cnt = e_cnt;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.flush_target = '0; bus.priv_hold = 1'b0; bus.priv_target = '0;
        bus.bp_redirect = 1'b0; bus.bp_target = '0; bus.if1_allowin = 1'b0;
        @(negedge clk); #1;

        //    rst fl  ft            ph  pt            br  bt            al  chk e_pc          vld ep  cnt
        step(1, 1, 32'h0000_1000, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1C00_0000, 1, 0, 16'd0);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 1, 32'h1C00_0000, 1, 0, 16'd0);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_0008, 1, 0, 16'd0);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_0010, 1, 0, 16'd0);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_0018, 1, 0, 16'd0);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 1, 32'h1C00_0018, 1, 0, 16'd0);
        // flush beats priv and predictor; target forced word aligned
        step(0, 1, 32'h1C00_1006, 1, 32'h1C00_7000, 1, 32'h1C00_9000, 1, 1, 32'h1C00_1004, 0, 1, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h1C00_9000, 1, 1, 32'h1C00_1004, 1, 1, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_1008, 1, 1, 16'd1);
        // privileged hold for four cycles
        step(0, 0, 32'h0,         1, 32'h1C00_0204, 1, 32'h1C00_9000, 1, 1, 32'h1C00_0204, 0, 1, 16'd1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 32'h0,     1, 32'h1C00_0204, 1, 32'h1C00_9000, 1, 1, 32'h1C00_0204, 0, 1, 16'd1);
        step(0, 0, 32'h0,         0, 32'h1C00_0204, 0, 32'h0,        0, 1, 32'h1C00_0204, 1, 2, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_0208, 1, 2, 16'd1);
        // predictor redirect with IF1 stalled
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h1C00_0500, 0, 1, 32'h1C00_0500, 1, 3, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_0508, 1, 3, 16'd1);
        // wrap at top of address space
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1, 0, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_0000, 1, 0, 16'd1);
        // five back-to-back redirects: epoch 1,2,3,0,1
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0100, 0, 1, 32'h0000_0100, 1, 1, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0200, 0, 1, 32'h0000_0200, 1, 2, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0300, 1, 1, 32'h0000_0300, 1, 3, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0400, 0, 1, 32'h0000_0400, 1, 0, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h0000_0500, 1, 1, 32'h0000_0500, 1, 1, 16'd1);
        // odd-word PC advances to the next 8-byte group
        step(0, 0, 32'h0,         0, 32'h0,        1, 32'h1C00_0504, 0, 1, 32'h1C00_0504, 1, 2, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h1C00_0508, 1, 2, 16'd1);
        // reset mid PRIV_WAIT dominates flush
        step(0, 0, 32'h0,         1, 32'h0000_3000, 0, 32'h0,        1, 1, 32'h0000_3000, 0, 2, 16'd1);
        step(1, 1, 32'h0000_2000, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1C00_0000, 1, 0, 16'd0);
        // reset mid FLUSH_BUB
        step(0, 1, 32'h0000_2000, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_2000, 0, 1, 16'd1);
        step(1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 1, 32'h1C00_0000, 1, 0, 16'd0);
        // FLUSH_BUB into PRIV_WAIT, then release
        step(0, 1, 32'h0000_4000, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0000_4000, 0, 1, 16'd1);
        step(0, 0, 32'h0,         1, 32'h0000_5000, 1, 32'h0000_9000, 1, 1, 32'h0000_4000, 0, 1, 16'd1);
        step(0, 0, 32'h0,         0, 32'h0000_5000, 0, 32'h0,        0, 1, 32'h0000_5000, 1, 2, 16'd1);
        // flush during PRIV_WAIT
        step(0, 0, 32'h0,         1, 32'h0000_6000, 0, 32'h0,        0, 1, 32'h0000_6000, 0, 2, 16'd1);
        step(0, 1, 32'h0000_7000, 1, 32'h0000_6000, 0, 32'h0,        0, 1, 32'h0000_7000, 0, 3, 16'd2);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_7000, 1, 3, 16'd2);
        // drive flush_cnt up to FFFE, then saturate
        for (int i = 0; i < 65532; i++)
            step(0, 1, 32'h0000_8000, 0, 32'h0,    0, 32'h0,        0, 0, 32'h0,         0, 0, 16'd0);
        step(0, 1, 32'h0000_8000, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_8000, 0, 0, 16'hFFFF);
        step(0, 1, 32'h0000_8000, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_8000, 0, 1, 16'hFFFF);
        step(0, 1, 32'h0000_8000, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_8000, 0, 2, 16'hFFFF);
        step(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_8000, 1, 2, 16'hFFFF);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
